// File: rtl/ast_packet_arbiter_pkg.sv
// Shared types and default sizing for the Avalon-ST packet arbiter slice.
package usr_types_and_params;

  localparam int unsigned N_SRC      = 4;
  localparam int unsigned DATA_IN_W  = 64;
  localparam int unsigned EMPTY_IN_W = 3;
  localparam int unsigned CHANNEL_W  = 2;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

endpackage

// File: rtl/ast_packet_arbiter_rr_arbiter.sv
// Combinational rotating-priority pick: first set request at index >= ptr, wrapping at N.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_vld
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] idx;

  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      // modulo on N rather than 2**IW keeps the scan off absent sources
      idx = IW'((32'(ptr) + k) % N);
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/ast_packet_arbiter.sv
// Packet-granular round-robin merge of N_SRC Avalon-ST sources; grant held SOP..EOP.
module ast_packet_arbiter #(
  parameter int unsigned N_SRC      = usr_types_and_params::N_SRC,
  parameter int unsigned DATA_IN_W  = usr_types_and_params::DATA_IN_W,
  parameter int unsigned EMPTY_IN_W = usr_types_and_params::EMPTY_IN_W,
  parameter int unsigned CHANNEL_W  = usr_types_and_params::CHANNEL_W
) (
  input  logic                          clk_i,
  input  logic                          srst_i,
  input  logic [N_SRC*DATA_IN_W-1:0]    src_data_i,
  input  logic [N_SRC-1:0]              src_sop_i,
  input  logic [N_SRC-1:0]              src_eop_i,
  input  logic [N_SRC-1:0]              src_valid_i,
  input  logic [N_SRC*EMPTY_IN_W-1:0]   src_empty_i,
  output logic [N_SRC-1:0]              src_ready_o,
  output logic [DATA_IN_W-1:0]          ast_data_o,
  output logic                          ast_startofpacket_o,
  output logic                          ast_endofpacket_o,
  output logic                          ast_valid_o,
  output logic [EMPTY_IN_W-1:0]         ast_empty_o,
  output logic [CHANNEL_W-1:0]          ast_channel_o,
  input  logic                          ast_ready_i,
  output logic                          proto_err_o
);

  import usr_types_and_params::*;

  localparam int unsigned IDX_W = $clog2(N_SRC);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] grant, grant_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
  logic             in_pkt, in_pkt_nxt;

  logic [N_SRC-1:0] req;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;

  logic [DATA_IN_W-1:0]  sel_data;
  logic [EMPTY_IN_W-1:0] sel_empty;
  logic                  sel_sop;
  logic                  sel_eop;
  logic                  sel_valid;

  assign req = src_valid_i & src_sop_i;

  rr_arbiter #(
    .N (N_SRC)
  ) u_rr_arbiter (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  assign sel_data  = src_data_i[32'(grant)*DATA_IN_W +: DATA_IN_W];
  assign sel_empty = src_empty_i[32'(grant)*EMPTY_IN_W +: EMPTY_IN_W];
  assign sel_sop   = src_sop_i[grant];
  assign sel_eop   = src_eop_i[grant];
  assign sel_valid = src_valid_i[grant];

  always_comb begin
    state_nxt           = state;
    grant_nxt           = grant;
    rr_ptr_nxt          = rr_ptr;
    in_pkt_nxt          = in_pkt;
    src_ready_o         = '0;
    ast_data_o          = '0;
    ast_startofpacket_o = 1'b0;
    ast_endofpacket_o   = 1'b0;
    ast_valid_o         = 1'b0;
    ast_empty_o         = '0;
    ast_channel_o       = '0;
    proto_err_o         = 1'b0;

    case (state)
      ARB_IDLE: begin
        if (pick_vld) begin
          grant_nxt  = pick_idx;
          rr_ptr_nxt = (pick_idx == IDX_W'(N_SRC - 1)) ? '0 : pick_idx + 1'b1;
          in_pkt_nxt = 1'b0;
          state_nxt  = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        ast_data_o          = sel_data;
        ast_startofpacket_o = sel_sop;
        ast_endofpacket_o   = sel_eop;
        ast_valid_o         = sel_valid;
        ast_empty_o         = sel_empty;
        ast_channel_o       = CHANNEL_W'(grant);
        src_ready_o[grant]  = ast_ready_i;
        if (sel_valid && ast_ready_i) begin
          // in_pkt marks that the opening SOP beat has already been taken
          proto_err_o = sel_sop && in_pkt;
          in_pkt_nxt  = 1'b1;
          if (sel_eop) begin
            state_nxt = ARB_IDLE;
          end
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state  <= ARB_IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      in_pkt <= 1'b0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_ptr_nxt;
      in_pkt <= in_pkt_nxt;
    end
  end

endmodule

// File: tb/tb_ast_packet_arbiter.sv
// Randomized bench for ast_packet_arbiter against a packet-queue reference model.
module tb_ast_packet_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned EW = 3;
  localparam int unsigned CW = 2;

  logic              clk = 1'b0;
  logic              srst;
  logic [N*DW-1:0]   src_data;
  logic [N-1:0]      src_sop, src_eop, src_valid, src_ready;
  logic [N*EW-1:0]   src_empty;
  logic [DW-1:0]     ast_data;
  logic              ast_sop, ast_eop, ast_valid, ast_ready, proto_err;
  logic [EW-1:0]     ast_empty;
  logic [CW-1:0]     ast_channel;

  always #5 clk = ~clk;

  ast_packet_arbiter #(
    .N_SRC      (N),
    .DATA_IN_W  (DW),
    .EMPTY_IN_W (EW),
    .CHANNEL_W  (CW)
  ) dut (
    .clk_i               (clk),
    .srst_i              (srst),
    .src_data_i          (src_data),
    .src_sop_i           (src_sop),
    .src_eop_i           (src_eop),
    .src_valid_i         (src_valid),
    .src_empty_i         (src_empty),
    .src_ready_o         (src_ready),
    .ast_data_o          (ast_data),
    .ast_startofpacket_o (ast_sop),
    .ast_endofpacket_o   (ast_eop),
    .ast_valid_o         (ast_valid),
    .ast_empty_o         (ast_empty),
    .ast_channel_o       (ast_channel),
    .ast_ready_i         (ast_ready),
    .proto_err_o         (proto_err)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } beat_t;

  beat_t       srcq [N][$];
  int          sop_chan [$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned valid_pct = 100;
  int unsigned ready_pct = 100;
  int unsigned n_perr    = 0;

  // reference model: current owner (-1 when none), next-first index, beats taken from owner
  int          m_owner = -1;
  int unsigned m_ptr   = 0;
  int unsigned m_beats = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic add_pkt(input int s, input int len, input int bad_sop_beat);
    beat_t t;
    for (int b = 0; b < len; b++) begin
      t.data  = {$urandom, $urandom};
      t.sop   = (b == 0) || (b == bad_sop_beat);
      t.eop   = (b == len - 1);
      t.empty = EW'($urandom);
      srcq[s].push_back(t);
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int s = 0; s < N; s++) n += srcq[s].size();
    return n;
  endfunction

  task automatic step(input logic rst);
    beat_t         head [N];
    logic [N-1:0]  e_rdy;
    logic [DW-1:0] e_data;
    logic [EW-1:0] e_empty;
    logic          e_valid, e_sop, e_eop, e_perr, hs;
    int            o;
    @(negedge clk);
    srst = rst;
    for (int s = 0; s < N; s++) begin
      if (srcq[s].size() > 0) begin
        head[s]      = srcq[s][0];
        src_valid[s] = ($urandom_range(99) < valid_pct);
      end else begin
        head[s]      = '0;
        src_valid[s] = 1'b0;
      end
      src_data[s*DW +: DW]  = head[s].data;
      src_sop[s]            = head[s].sop;
      src_eop[s]            = head[s].eop;
      src_empty[s*EW +: EW] = head[s].empty;
    end
    ast_ready = ($urandom_range(99) < ready_pct);
    #1;
    o = m_owner;
    e_rdy = '0; e_data = '0; e_empty = '0;
    e_valid = 1'b0; e_sop = 1'b0; e_eop = 1'b0; e_perr = 1'b0; hs = 1'b0;
    if (o >= 0) begin
      e_valid  = src_valid[o];
      e_rdy[o] = ast_ready;
      e_data   = head[o].data;
      e_sop    = head[o].sop;
      e_eop    = head[o].eop;
      e_empty  = head[o].empty;
      hs       = e_valid && ast_ready;
      e_perr   = hs && head[o].sop && (m_beats > 0);
    end
    check("valid",   64'(ast_valid),   64'(e_valid));
    check("ready",   64'(src_ready),   64'(e_rdy));
    check("channel", 64'(ast_channel), (o >= 0) ? 64'(o) : 64'd0);
    check("data",    ast_data,         e_data);
    check("sop",     64'(ast_sop),     64'(e_sop));
    check("eop",     64'(ast_eop),     64'(e_eop));
    check("empty",   64'(ast_empty),   64'(e_empty));
    check("proto_err", 64'(proto_err), 64'(e_perr));
    if (proto_err) n_perr++;
    if (hs && m_beats == 0) sop_chan.push_back(int'(ast_channel));
    @(posedge clk);
    if (hs) begin
      void'(srcq[o].pop_front());
      m_beats++;
      if (head[o].eop) m_owner = -1;
    end
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      // an abandoned packet's remaining beats are withdrawn by its source
      for (int s = 0; s < N; s++)
        while (srcq[s].size() > 0 && !srcq[s][0].sop) void'(srcq[s].pop_front());
    end else if (o < 0) begin
      for (int k = 0; k < N; k++) begin
        int s = int'((m_ptr + k) % N);
        if (m_owner < 0 && src_valid[s] && head[s].sop) begin
          m_owner = s;
          m_ptr   = (s + 1) % N;
          m_beats = 0;
        end
      end
    end
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while ((pending() > 0 || m_owner >= 0) && c < budget) begin
      step(1'b0);
      c++;
    end
    check("drain_left", 64'(pending()), 64'd0);
  endtask

  initial begin
    srst = 1'b1; ast_ready = 1'b0;
    src_valid = '0; src_sop = '0; src_eop = '0; src_data = '0; src_empty = '0;
    repeat (3) @(posedge clk);
    step(1'b0);

    // all sources with single-beat packets, twice: strict 0,1,2,3 rotation
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < N; s++) add_pkt(s, 1, -1);
    sop_chan.delete();
    drain(200);
    check("order_cnt", 64'(sop_chan.size()), 64'd8);
    for (int i = 0; i < 8 && i < sop_chan.size(); i++)
      check("order", 64'(sop_chan[i]), 64'(i % 4));

    // lone 3-beat packet on source 2
    sop_chan.delete();
    add_pkt(2, 3, -1);
    drain(100);
    check("solo_chan", (sop_chan.size() > 0) ? 64'(sop_chan[0]) : 64'hFF, 64'd2);

    // source 1 with a stray SOP on beat 2 of 4, under backpressure
    n_perr = 0;
    ready_pct = 50;
    add_pkt(1, 4, 1);
    drain(200);
    check("perr_cnt", 64'(n_perr), 64'd1);
    ready_pct = 100;

    // reset during beat 2 of 5, then a fresh request from source 3
    add_pkt(0, 5, -1);
    for (int c = 0; c < 50 && !(m_owner == 0 && m_beats == 1); c++) step(1'b0);
    check("pre_reset_beats", 64'(m_beats), 64'd1);
    step(1'b1);
    step(1'b0);
    sop_chan.delete();
    add_pkt(3, 2, -1);
    drain(100);
    check("post_reset_chan", (sop_chan.size() > 0) ? 64'(sop_chan[0]) : 64'hFF, 64'd3);

    // random traffic with valid gaps and backpressure
    valid_pct = 70;
    ready_pct = 60;
    for (int p = 0; p < 200; p++) begin
      add_pkt(int'($urandom_range(N - 1)), int'($urandom_range(5, 1)),
              ($urandom_range(9) == 0) ? 1 : -1);
      if (pending() > 12) drain(2000);
    end
    drain(4000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
